bitsound_mixer: RTL and testbench

//  Multi-channel successor to the single-bit ±VOLUME mapper.

---
 rtl/bitsound_mixer.sv | 131 +++++++++++++
 tb/tb_bitsound_mixer.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitsound_mixer.sv
// bitsound_mixer
// Multi-channel one-bit audio mixer. Each asynchronous source bit is brought
// into the audio clock through a two-flop synchroniser and mapped to a signed
// level of +/- its runtime volume. On each sample tick, every level slews
// toward its target by at most STEP. On the following edge, all levels are
// summed with saturation and presented on dout.
//
// Output semantics: dout_valid is a one-cycle strobe with no backpressure.
// dout changes only on cycles where dout_valid is 1, and holds its value
// in between. Back-to-back ticks produce one strobe per tick.
module bitsound_mixer #(
  parameter int                  AUDIO_DW = 16,
  parameter int                  CHANNELS = 3,
  parameter logic [AUDIO_DW-1:0] STEP     = 16'h0400
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CHANNELS-1:0]          din,
  input  logic [CHANNELS-1:0]          ch_en,
  input  logic [CHANNELS*AUDIO_DW-1:0] vol,
  input  logic                         sample_en,
  output logic [AUDIO_DW-1:0]          dout,
  output logic                         dout_valid
);

  localparam int DW1 = AUDIO_DW + 1;  // slew difference width
  localparam int SW  = AUDIO_DW + 3;  // mix accumulator width, enough for 8 channels

  // Largest positive sample; volumes above this are clamped to it.
  localparam logic [AUDIO_DW-1:0]  MAG_MAX = {1'b0, {(AUDIO_DW-1){1'b1}}};
  localparam logic signed [DW1-1:0] STEP_X = {1'b0, STEP};
  localparam logic signed [SW-1:0] SUM_MAX = {4'b0000, {(AUDIO_DW-1){1'b1}}};
  localparam logic signed [SW-1:0] SUM_MIN = {4'b1111, {(AUDIO_DW-1){1'b0}}};

  logic [CHANNELS-1:0]         sync1;
  logic [CHANNELS-1:0]         sync2;
  logic [AUDIO_DW-1:0]         mag       [CHANNELS];
  logic signed [AUDIO_DW-1:0]  target    [CHANNELS];
  logic signed [AUDIO_DW-1:0]  level     [CHANNELS];
  logic signed [AUDIO_DW-1:0]  level_nxt [CHANNELS];
  logic signed [DW1-1:0]       diff      [CHANNELS];
  logic signed [SW-1:0]        sum;
  logic signed [AUDIO_DW-1:0]  mix_sat;
  logic                        upd;

  // Two-flop synchroniser per source bit; din is asynchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  // Target level per channel: clamped volume, signed by the synchronised bit.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      mag[i] = vol[i*AUDIO_DW +: AUDIO_DW];
      if (mag[i] > MAG_MAX) begin
        mag[i] = MAG_MAX;
      end
      if (!ch_en[i]) begin
        target[i] = '0;
      end else if (sync2[i]) begin
        target[i] = $signed(mag[i]);
      end else begin
        target[i] = -$signed(mag[i]);
      end
    end
  end

  // Slew limiter: move at most STEP toward the target, never past it.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      diff[i] = {target[i][AUDIO_DW-1], target[i]} - {level[i][AUDIO_DW-1], level[i]};
      if (STEP == '0 || (diff[i] <= STEP_X && diff[i] >= -STEP_X)) begin
        level_nxt[i] = target[i];
      end else if (diff[i] > STEP_X) begin
        level_nxt[i] = level[i] + STEP;
      end else begin
        level_nxt[i] = level[i] - STEP;
      end
    end
  end

  // Channel levels advance only on a sample tick and clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        level[i] <= '0;
      end
    end else if (sample_en) begin
      for (int i = 0; i < CHANNELS; i++) begin
        level[i] <= level_nxt[i];
      end
    end
  end

  // Wide sum of all levels, then clamp into the signed sample range.
  always_comb begin
    sum = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sum = sum + SW'(level[i]);
    end
    if (sum > SUM_MAX) begin
      mix_sat = SUM_MAX[AUDIO_DW-1:0];
    end else if (sum < SUM_MIN) begin
      mix_sat = SUM_MIN[AUDIO_DW-1:0];
    end else begin
      mix_sat = sum[AUDIO_DW-1:0];
    end
  end

  // Register the mix one edge after each level update and strobe it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd        <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      upd        <= sample_en;
      dout_valid <= upd;
      if (upd) begin
        dout <= mix_sat;
      end
    end
  end

endmodule

// File: tb/tb_bitsound_mixer.sv
// Testbench for bitsound_mixer: a 3-channel slewed instance and a
// 1-channel instance with STEP=0, both checked against an arithmetic model.
module tb_bitsound_mixer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  din;
  logic [2:0]  ch_en;
  logic [47:0] vol;
  logic        sample_en;
  logic [15:0] dout;
  logic        dout_valid;

  logic [0:0]  din1;
  logic [0:0]  en1;
  logic [15:0] vol1;
  logic [15:0] dout1;
  logic        dout_valid1;

  bitsound_mixer #(.AUDIO_DW(16), .CHANNELS(3), .STEP(16'h0400)) u_dut (
    .clk(clk), .rst_n(rst_n), .din(din), .ch_en(ch_en), .vol(vol),
    .sample_en(sample_en), .dout(dout), .dout_valid(dout_valid)
  );

  bitsound_mixer #(.AUDIO_DW(16), .CHANNELS(1), .STEP(16'h0000)) u_nos (
    .clk(clk), .rst_n(rst_n), .din(din1), .ch_en(en1), .vol(vol1),
    .sample_en(sample_en), .dout(dout1), .dout_valid(dout_valid1)
  );

  int vectors = 0;
  int errs = 0;

  // ---------------- reference model ----------------
  int mlev [3];
  int nlev;
  logic [15:0] exp_q [$];

  function automatic int tgt(logic d, logic e, int v);
    int m;
    m = (v > 32767) ? 32767 : v;
    if (!e) return 0;
    return d ? m : -m;
  endfunction

  function automatic int slew(int lev, int t, int step);
    int d;
    d = t - lev;
    if (step == 0 || (d <= step && d >= -step)) return t;
    return (d > 0) ? lev + step : lev - step;
  endfunction

  function automatic logic [15:0] sat(int s);
    int c;
    c = (s > 32767) ? 32767 : ((s < -32768) ? -32768 : s);
    return c[15:0];
  endfunction

  function automatic int msum();
    return mlev[0] + mlev[1] + mlev[2];
  endfunction

  function automatic void model_tick();
    for (int c = 0; c < 3; c++) begin
      mlev[c] = slew(mlev[c], tgt(din[c], ch_en[c], int'(vol[c*16 +: 16])), 1024);
    end
    nlev = slew(nlev, tgt(din1[0], en1[0], int'(vol1)), 0);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  // One isolated sample tick; starts and ends on a falling edge.
  task automatic tick(output logic v0, output logic v1,
                      output logic [15:0] o3, output logic [15:0] o1);
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    v0 = dout_valid;
    model_tick();
    @(negedge clk);
    v1 = dout_valid;
    o3 = dout;
    o1 = dout1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    vectors++;
    if (dout !== 16'h0000 || dout_valid !== 1'b0) begin
      errs++;
      $display("FAIL reset_hold: dout=%h valid=%b expected 0000/0", dout, dout_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (dout !== 16'h0000 || dout_valid !== 1'b0 || dout1 !== 16'h0000) begin
      errs++;
      $display("FAIL reset_release: dout=%h valid=%b dout1=%h expected 0", dout, dout_valid, dout1);
    end
  endtask

  task automatic test_single_nos();
    logic v0, v1;
    logic [15:0] o3, o1;
    vol1 = 16'h2000; din1 = 1'b1; en1 = 1'b1;
    settle();
    tick(v0, v1, o3, o1);
    vectors++;
    if (o1 !== 16'h2000 || v0 !== 1'b0 || dout_valid1 !== 1'b1) begin
      errs++;
      $display("FAIL nos_jump: dout1=%h early_valid=%b valid1=%b expected 2000/0/1", o1, v0, dout_valid1);
    end
    vectors++;
    if (o3 !== sat(msum()) || v1 !== 1'b1) begin
      errs++;
      $display("FAIL idle_mix: dout=%h valid=%b expected %h/1", o3, v1, sat(msum()));
    end
    @(negedge clk);
    vectors++;
    if (dout_valid1 !== 1'b0 || dout1 !== 16'h2000) begin
      errs++;
      $display("FAIL nos_strobe_width: valid1=%b dout1=%h expected 0/2000", dout_valid1, dout1);
    end
  endtask

  task automatic test_ramp();
    logic v0, v1;
    logic [15:0] o3, o1;
    ch_en = 3'b001; vol[15:0] = 16'h1000; din = 3'b000;
    settle();
    repeat (4) begin
      tick(v0, v1, o3, o1);
      vectors++;
      if (o3 !== sat(msum()) || v1 !== 1'b1) begin
        errs++;
        $display("FAIL ramp_down: dout=%h valid=%b expected %h/1", o3, v1, sat(msum()));
      end
    end
    vectors++;
    if (o3 !== 16'hF000) begin
      errs++;
      $display("FAIL ramp_settle: dout=%h expected f000", o3);
    end
    din = 3'b001;
    settle();
    for (int k = 1; k <= 8; k++) begin
      tick(v0, v1, o3, o1);
      vectors++;
      if (o3 !== sat(-4096 + 1024 * k)) begin
        errs++;
        $display("FAIL ramp_up_step%0d: dout=%h expected %h", k, o3, sat(-4096 + 1024 * k));
      end
    end
  endtask

  task automatic test_flip();
    logic v0, v1;
    logic [15:0] o3, o1;
    din = 3'b000;
    settle();
    repeat (8) tick(v0, v1, o3, o1);
    vectors++;
    if (o3 !== 16'hF000) begin
      errs++;
      $display("FAIL flip_floor: dout=%h expected f000", o3);
    end
    din = 3'b001;
    settle();
    repeat (6) tick(v0, v1, o3, o1);
    vectors++;
    if (o3 !== 16'h0800) begin
      errs++;
      $display("FAIL flip_midramp: dout=%h expected 0800", o3);
    end
    din = 3'b000;
    settle();
    tick(v0, v1, o3, o1);
    vectors++;
    if (o3 !== 16'h0400) begin
      errs++;
      $display("FAIL flip_reverse: dout=%h expected 0400", o3);
    end
    din = 3'b001;
    settle();
    repeat (3) tick(v0, v1, o3, o1);
    vectors++;
    if (o3 !== 16'h1000 || o3 !== sat(msum())) begin
      errs++;
      $display("FAIL flip_top: dout=%h expected 1000", o3);
    end
    ch_en = 3'b000;
    settle();
    for (int k = 1; k <= 4; k++) begin
      tick(v0, v1, o3, o1);
      vectors++;
      if (o3 !== sat(4096 - 1024 * k)) begin
        errs++;
        $display("FAIL disable_ramp%0d: dout=%h expected %h", k, o3, sat(4096 - 1024 * k));
      end
    end
  endtask

  task automatic test_sync_latency();
    logic v0, v1;
    logic [15:0] o3, o1;
    ch_en = 3'b001; vol[15:0] = 16'h0100; din = 3'b000;
    settle();
    tick(v0, v1, o3, o1);
    vectors++;
    if (o3 !== 16'hFF00) begin
      errs++;
      $display("FAIL sync_pre: dout=%h expected ff00", o3);
    end
    din = 3'b001;
    sample_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (dout !== 16'hFF00 || dout_valid !== 1'b1) begin
      errs++;
      $display("FAIL sync_edge1: dout=%h valid=%b expected ff00/1", dout, dout_valid);
    end
    @(negedge clk);
    sample_en = 1'b0;
    vectors++;
    if (dout !== 16'hFF00) begin
      errs++;
      $display("FAIL sync_edge2: dout=%h expected ff00", dout);
    end
    @(negedge clk);
    vectors++;
    if (dout !== 16'h0100 || dout_valid !== 1'b1) begin
      errs++;
      $display("FAIL sync_edge3: dout=%h valid=%b expected 0100/1", dout, dout_valid);
    end
    mlev[0] = 256;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    ch_en = 3'b001; vol[15:0] = 16'h7FFF; din = 3'b000;
    settle();
    exp_q.delete();
    sample_en = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      if (i > 0) begin
        vectors++;
        if (dout_valid === 1'b1) pulses++;
        if (dout_valid !== 1'b1 || dout !== exp_q[0]) begin
          errs++;
          $display("FAIL b2b_cycle%0d: dout=%h valid=%b expected %h/1", i, dout, dout_valid, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      if (i < 10) begin
        model_tick();
        exp_q.push_back(sat(msum()));
      end
      if (i == 9) sample_en = 1'b0;
    end
    @(negedge clk);
    vectors++;
    if (dout_valid !== 1'b0 || pulses != 10 || dout !== sat(256 - 10240)) begin
      errs++;
      $display("FAIL b2b_total: pulses=%0d valid=%b dout=%h expected 10/0/%h", pulses, dout_valid, dout, sat(256 - 10240));
    end
  endtask

  task automatic test_saturation();
    logic v0, v1;
    logic [15:0] o3, o1;
    ch_en = 3'b111; vol = {3{16'h7FFF}}; din = 3'b111;
    settle();
    repeat (50) begin
      tick(v0, v1, o3, o1);
      vectors++;
      if (o3 !== sat(msum())) begin
        errs++;
        $display("FAIL sat_up: dout=%h expected %h", o3, sat(msum()));
      end
    end
    vectors++;
    if (o3 !== 16'h7FFF) begin
      errs++;
      $display("FAIL sat_pos: dout=%h expected 7fff", o3);
    end
    din = 3'b000;
    settle();
    repeat (70) begin
      tick(v0, v1, o3, o1);
      vectors++;
      if (o3 !== sat(msum())) begin
        errs++;
        $display("FAIL sat_down: dout=%h expected %h", o3, sat(msum()));
      end
    end
    vectors++;
    if (o3 !== 16'h8000) begin
      errs++;
      $display("FAIL sat_neg: dout=%h expected 8000", o3);
    end
  endtask

  task automatic test_reset_mid_ramp();
    logic v0, v1;
    logic [15:0] o3, o1;
    din = 3'b111;
    settle();
    repeat (3) tick(v0, v1, o3, o1);
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (dout !== 16'h0000 || dout_valid !== 1'b0 || dout1 !== 16'h0000) begin
      errs++;
      $display("FAIL reset_async: dout=%h valid=%b dout1=%h expected 0/0/0", dout, dout_valid, dout1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) mlev[c] = 0;
    nlev = 0;
    settle();
    tick(v0, v1, o3, o1);
    vectors++;
    if (o3 !== 16'h0C00 || o1 !== 16'h2000 || v1 !== 1'b1) begin
      errs++;
      $display("FAIL reset_restart: dout=%h dout1=%h valid=%b expected 0c00/2000/1", o3, o1, v1);
    end
  endtask

  task automatic test_random();
    logic v0, v1;
    logic [15:0] o3, o1;
    for (int n = 0; n < 30; n++) begin
      din   = 3'($urandom_range(0, 7));
      ch_en = 3'($urandom_range(0, 7));
      for (int c = 0; c < 3; c++) vol[c*16 +: 16] = 16'($urandom_range(0, 65535));
      din1  = 1'($urandom_range(0, 1));
      en1   = 1'($urandom_range(0, 1));
      vol1  = 16'($urandom_range(0, 65535));
      settle();
      repeat ($urandom_range(1, 4)) begin
        tick(v0, v1, o3, o1);
        vectors++;
        if (o3 !== sat(msum()) || o1 !== sat(nlev) || v0 !== 1'b0 || v1 !== 1'b1) begin
          errs++;
          $display("FAIL random%0d: dout=%h dout1=%h v=%b%b expected %h/%h/01", n, o3, o1, v0, v1, sat(msum()), sat(nlev));
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    din = '0; ch_en = '0; vol = '0; sample_en = 1'b0;
    din1 = '0; en1 = '0; vol1 = '0;
    for (int c = 0; c < 3; c++) mlev[c] = 0;
    nlev = 0;
    repeat (3) @(negedge clk);
    test_reset();
    test_single_nos();
    test_ramp();
    test_flip();
    test_sync_latency();
    test_back_to_back();
    test_saturation();
    test_reset_mid_ramp();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #500000;
    errs++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
